// File: rtl/minilab_pkg.sv
// Shared Minilab1 definitions: default array geometry and the loader FSM state type.
package minilab_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int NUM_ROWS   = 8;
    localparam int ROW_LEN    = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        DONE
    } loader_state_t;
endpackage

// File: rtl/row_serializer.sv
// Row serializer: latches one memory word and emits its elements LSB-first to one target FIFO.
// Latency: first element one cycle after load, then one element per cycle.
// Backpressure: the target's full flag gates wrreq in the same cycle and holds the element.
module row_serializer
    import minilab_pkg::*;
#(
    parameter int DATA_WIDTH = minilab_pkg::DATA_WIDTH,
    parameter int ROW_LEN    = minilab_pkg::ROW_LEN,
    parameter int NUM_FIFOS  = minilab_pkg::NUM_ROWS + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [DATA_WIDTH*ROW_LEN-1:0] row_dat,
    input  logic [NUM_FIFOS-1:0]          tgt_sel,
    input  logic [NUM_FIFOS-1:0]          fifo_wrfull,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [NUM_FIFOS-1:0]          fifo_wrreq,
    output logic                          last
);
    localparam int IDX_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    logic [DATA_WIDTH*ROW_LEN-1:0] row_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          vld_q;
    logic [NUM_FIFOS-1:0]          tgt_q;
    logic                          stall;
    logic                          fire;

    // Full is sampled in the write cycle itself, so it masks the registered strobe directly.
    assign stall      = |(tgt_q & fifo_wrfull);
    assign fire       = vld_q & ~stall;
    assign fifo_wrreq = fire ? tgt_q : '0;
    assign fifo_data  = row_q[DATA_WIDTH-1:0];
    assign last       = fire && (idx_q == IDX_W'(ROW_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            idx_q <= '0;
            vld_q <= 1'b0;
            tgt_q <= '0;
        end else if (load) begin
            row_q <= row_dat;
            idx_q <= '0;
            vld_q <= 1'b1;
            tgt_q <= tgt_sel;
        end else if (fire) begin
            row_q <= row_q >> DATA_WIDTH;
            idx_q <= idx_q + 1'b1;
            if (last) begin
                vld_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/matrix_fifo_loader.sv
// Loads NUM_ROWS A rows plus one B row from Avalon-MM into per-row FIFOs; optional MINILAB_LOAD_CYCLES_EN cycle counter.
// Latency: 10 cycles per word unstalled, done in cycle 91 for 8x8 bytes.
// Backpressure: waitrequest holds the read, fifo_wrfull holds the current element; each adds one cycle.
module matrix_fifo_loader
    import minilab_pkg::*;
#(
    parameter int                  DATA_WIDTH = minilab_pkg::DATA_WIDTH,
    parameter int                  NUM_ROWS   = minilab_pkg::NUM_ROWS,
    parameter int                  ROW_LEN    = minilab_pkg::ROW_LEN,
    parameter int                  ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH-1:0]         avm_address,
    output logic                          avm_read,
    input  logic [DATA_WIDTH*ROW_LEN-1:0] avm_readdata,
    input  logic                          avm_readdatavalid,
    input  logic                          avm_waitrequest,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [NUM_ROWS:0]             fifo_wrreq,
    input  logic [NUM_ROWS:0]             fifo_wrfull,
    output logic [15:0]                   load_cycles
);
    localparam int NF  = NUM_ROWS + 1;
    localparam int W_W = $clog2(NF);

    loader_state_t  state_q;
    logic [W_W-1:0] word_q;
    logic [NF-1:0]  tgt_sel;
    logic           ser_load;
    logic           ser_last;

    assign tgt_sel  = NF'(1) << word_q;
    assign ser_load = (state_q == WAIT) && avm_readdatavalid;

    row_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_LEN    (ROW_LEN),
        .NUM_FIFOS  (NF)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ser_load),
        .row_dat     (avm_readdata),
        .tgt_sel     (tgt_sel),
        .fifo_wrfull (fifo_wrfull),
        .fifo_data   (fifo_data),
        .fifo_wrreq  (fifo_wrreq),
        .last        (ser_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q     <= REQ;
                        word_q      <= '0;
                        busy        <= 1'b1;
                        avm_read    <= 1'b1;
                        avm_address <= BASE_ADDR;
                    end
                end
                REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (avm_readdatavalid) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ser_last) begin
                        if (word_q == W_W'(NUM_ROWS)) begin
                            state_q <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            word_q      <= word_q + 1'b1;
                            state_q     <= REQ;
                            avm_read    <= 1'b1;
                            avm_address <= BASE_ADDR + ADDR_WIDTH'(word_q) + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MINILAB_LOAD_CYCLES_EN
    logic [15:0] cnt_q;

    // Every non-IDLE cycle counts, so the DONE cycle lands in the total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                cnt_q <= '0;
            end
        end else if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign load_cycles = cnt_q;
`else
    assign load_cycles = '0;
`endif
endmodule

// File: tb/tb_matrix_fifo_loader.sv
// Bench for matrix_fifo_loader: Avalon memory model, per-FIFO scoreboard queues, cycle-accurate done timing.
module tb_matrix_fifo_loader;
    localparam int DW = 8;
    localparam int NR = 8;
    localparam int RL = 8;
    localparam int AW = 32;
    localparam int NF = NR + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [AW-1:0]     avm_address;
    logic              avm_read;
    logic [DW*RL-1:0]  avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;
    logic              avm_waitrequest = 1'b0;
    logic [DW-1:0]     fifo_data;
    logic [NF-1:0]     fifo_wrreq;
    logic [NF-1:0]     fifo_wrfull = '0;
    logic [15:0]       load_cycles;

    matrix_fifo_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest),
        .fifo_data         (fifo_data),
        .fifo_wrreq        (fifo_wrreq),
        .fifo_wrfull       (fifo_wrfull),
        .load_cycles       (load_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [DW*RL-1:0] mem [NF];
    logic [DW-1:0]    exp_q [NF][$];
    int               got_cnt [NF];
    int               reads = 0;
    int               dones = 0;
    int               done_cyc = -1;

    int ws_word = -1;
    int ws_left = 0;
    int full_fifo = 0;
    int full_after = 0;
    int full_left = 0;
    bit rand_stall = 1'b0;
    int extra = 0;

    logic          acc = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Slave side: read data one cycle after acceptance, plus injected waitrequest/full stalls.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        avm_readdatavalid = acc && rst_n;
        if (acc && acc_addr < AW'(NF)) avm_readdata = mem[acc_addr];
        else avm_readdata = {$urandom, $urandom};
        avm_waitrequest = 1'b0;
        if (avm_read) begin
            if (ws_left > 0 && avm_address == AW'(ws_word)) begin
                avm_waitrequest = 1'b1;
                ws_left--;
                extra++;
            end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                avm_waitrequest = 1'b1;
                extra++;
            end
        end
        fifo_wrfull = '0;
        if (full_left > 0 && got_cnt[full_fifo] >= full_after && got_cnt[full_fifo] < RL) begin
            fifo_wrfull[full_fifo] = 1'b1;
            full_left--;
            extra++;
        end else if (rand_stall) begin
            for (int k = 0; k < NF; k++) begin
                if (got_cnt[k] > 0 && got_cnt[k] < RL && $urandom_range(0, 2) == 0) begin
                    fifo_wrfull[k] = 1'b1;
                    extra++;
                end else if (got_cnt[k] == RL && $urandom_range(0, 1) == 0) begin
                    fifo_wrfull[k] = 1'b1;
                end
            end
        end
    end

    // Monitor: bus protocol checks and scoreboard pops on every FIFO write.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
            acc = 1'b0;
        end else begin
            if (prev_stall) begin
                check("addr_hold", avm_address, prev_addr);
                check("read_hold", avm_read, 1);
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            acc        = avm_read && !avm_waitrequest;
            acc_addr   = avm_address;
            if (acc) reads++;
            if (fifo_wrreq != '0) begin
                check("wrreq_onehot", $countones(fifo_wrreq), 1);
                check("wrreq_while_full", |(fifo_wrreq & fifo_wrfull), 0);
                for (int k = 0; k < NF; k++) begin
                    if (fifo_wrreq[k]) begin
                        if (exp_q[k].size() == 0) check($sformatf("fifo%0d_extra_write", k), 0, 1);
                        else check($sformatf("fifo%0d_data", k), fifo_data, exp_q[k].pop_front());
                        got_cnt[k]++;
                    end
                end
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic arm_load();
        for (int k = 0; k < NF; k++) begin
            got_cnt[k] = 0;
            exp_q[k].delete();
            for (int j = 0; j < RL; j++) exp_q[k].push_back(mem[k][DW*j +: DW]);
        end
        reads = 0;
        dones = 0;
        done_cyc = -1;
        extra = 0;
    endtask

    task automatic do_load(input string tag, input bit repulse);
        int t0;
        int n;
        longint exp_lc;
        arm_load();
        @(posedge clk);
        #2;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #2;
        start = 1'b0;
        #1;
        check({tag, "_busy_c1"}, busy, 1);
        check({tag, "_read_c1"}, avm_read, 1);
        check({tag, "_addr_c1"}, avm_address, 0);
        n = 0;
        do begin
            @(posedge clk);
            #3;
            start = repulse && done_cyc < 0 && ($urandom_range(0, 9) == 0);
            n++;
        end while (done_cyc < 0 && n < 3000);
        start = 1'b0;
        if (done_cyc < 0) check({tag, "_done_timeout"}, n, 0);
        check({tag, "_done_cycle"}, done_cyc - t0, 91 + extra);
        exp_lc = 91 + extra;
        if (exp_lc > 65535) exp_lc = 65535;
        repeat (20) @(posedge clk);
        #3;
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_read_count"}, reads, NF);
        check({tag, "_busy_idle"}, busy, 0);
        for (int k = 0; k < NF; k++) check($sformatf("%s_fifo%0d_count", tag, k), got_cnt[k], RL);
`ifdef MINILAB_LOAD_CYCLES_EN
        check({tag, "_load_cycles"}, load_cycles, exp_lc);
`else
        check({tag, "_load_cycles"}, load_cycles, 0);
`endif
    endtask

    task automatic randomize_mem();
        for (int k = 0; k < NF; k++) mem[k] = {$urandom, $urandom};
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_wrreq", fifo_wrreq, 0);
        check("rst_data", fifo_data, 0);
        check("rst_load_cycles", load_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int k = 0; k < NF; k++)
            for (int j = 0; j < RL; j++) mem[k][DW*j +: DW] = DW'(RL * k + j);
        do_load("pattern", 1'b0);

        ws_word = 4;
        ws_left = 3;
        do_load("waitreq", 1'b0);
        ws_left = 0;

        full_fifo = 2;
        full_after = 3;
        full_left = 5;
        do_load("full2", 1'b0);
        full_left = 0;

        randomize_mem();
        do_load("repulse", 1'b1);

        randomize_mem();
        arm_load();
        @(posedge clk);
        #2;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        n = 0;
        while (got_cnt[3] < 2 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (got_cnt[3] < 2) check("reset_wait_timeout", n, 0);
        #4;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_read", avm_read, 0);
        check("midrst_addr", avm_address, 0);
        check("midrst_wrreq", fifo_wrreq, 0);
        check("midrst_data", fifo_data, 0);
        check("midrst_load_cycles", load_cycles, 0);
        for (int k = 0; k < NF; k++) exp_q[k].delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        randomize_mem();
        do_load("after_rst", 1'b0);

        rand_stall = 1'b1;
        for (int r = 0; r < 3; r++) begin
            randomize_mem();
            do_load($sformatf("rand%0d", r), r == 1);
        end
        rand_stall = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
